gpi_input_conditioner: RTL

//  Receive-side companion to the GPO pad driver: conditions the raw digital input of a GPIO pad cell

---
 rtl/gpi_input_conditioner_if.sv | 42 ++++
 rtl/gpi_input_conditioner.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/gpi_input_conditioner_if.sv
// Signal bundle between the GPIO register block / pad ring (master) and the
// input conditioner (slave). The edge-counter signals exist only when
// GPI_EDGE_COUNT_EN is defined.
interface gpi_input_conditioner_if #(
   parameter int FILT_W = 8
`ifdef GPI_EDGE_COUNT_EN
   , parameter int CNT_W = 16
`endif
);
   logic              pad_di_i;
   logic              en_i;
   logic [FILT_W-1:0] filt_len_i;
   logic [2:0]        irq_mode_i;
   logic              irq_clr_i;
   logic              ie_o;
   logic              data_o;
   logic              rise_o;
   logic              fall_o;
   logic              irq_o;
`ifdef GPI_EDGE_COUNT_EN
   logic              cnt_clr_i;
   logic [CNT_W-1:0]  edge_cnt_o;

   modport master (
      output pad_di_i, en_i, filt_len_i, irq_mode_i, irq_clr_i, cnt_clr_i,
      input  ie_o, data_o, rise_o, fall_o, irq_o, edge_cnt_o
   );
   modport slave (
      input  pad_di_i, en_i, filt_len_i, irq_mode_i, irq_clr_i, cnt_clr_i,
      output ie_o, data_o, rise_o, fall_o, irq_o, edge_cnt_o
   );
`else
   modport master (
      output pad_di_i, en_i, filt_len_i, irq_mode_i, irq_clr_i,
      input  ie_o, data_o, rise_o, fall_o, irq_o
   );
   modport slave (
      input  pad_di_i, en_i, filt_len_i, irq_mode_i, irq_clr_i,
      output ie_o, data_o, rise_o, fall_o, irq_o
   );
`endif
endinterface

// File: rtl/gpi_input_conditioner.sv
// GPIO input conditioner: synchronises the raw pad input, rejects glitches
// shorter than filt_len_i cycles, produces edge strobes and an interrupt.
// Optional accepted-edge counter enabled by defining GPI_EDGE_COUNT_EN.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   STABLE  | synchronised input agrees with data_o, counter idle
//   QUALIFY | input differs from data_o, counting stable cycles
module gpi_input_conditioner #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_W      = 8
`ifdef GPI_EDGE_COUNT_EN
   , parameter int CNT_W     = 16
`endif
) (
   input logic                    clk,
   input logic                    rst_n,
   gpi_input_conditioner_if.slave bus
);
   typedef enum logic {ST_STABLE, ST_QUALIFY} state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync;
   state_t                 state_q, state_d;
   logic [FILT_W-1:0]      cnt_q, cnt_d;
   logic                   accept;
   logic                   data_q, data_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   ie_q;
   logic                   irq_q, irq_d;
   logic [2:0]             mode_q;
   logic                   sticky;

   assign sync = sync_q[SYNC_STAGES-1];

   // Plain shift-register synchroniser, flushed while disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          sync_q <= '0;
      else if (!bus.en_i)  sync_q <= '0;
      else                 sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pad_di_i};
   end

   // Filter state register together with the filtered level and strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_STABLE;
         cnt_q   <= '0;
         data_q  <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else if (!bus.en_i) begin
         state_q <= ST_STABLE;
         cnt_q   <= '0;
         data_q  <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // Next state: qualify a level change for filt_len_i cycles (live value)
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      if (bus.filt_len_i == '0) begin
         state_d = ST_STABLE;
         cnt_d   = '0;
         accept  = (sync != data_q);
      end else begin
         case (state_q)
            ST_STABLE: begin
               if (sync != data_q) begin
                  state_d = ST_QUALIFY;
                  cnt_d   = FILT_W'(1);
               end else begin
                  cnt_d   = '0;
               end
            end
            ST_QUALIFY: begin
               if (sync == data_q) begin
                  state_d = ST_STABLE;
                  cnt_d   = '0;
               end else if (cnt_q >= bus.filt_len_i) begin
                  accept  = 1'b1;
                  state_d = ST_STABLE;
                  cnt_d   = '0;
               end else if (cnt_q != '1) begin
                  cnt_d   = cnt_q + FILT_W'(1);
               end
            end
            default: begin
               state_d = ST_STABLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Outputs: accepted level and the matching one-cycle strobe
   always_comb begin
      data_d = accept ? sync : data_q;
      rise_d = accept &  sync;
      fall_d = accept & ~sync;
   end

   // Interrupt next value; a mode change drops any sticky edge interrupt
   always_comb begin
      sticky = (bus.irq_mode_i == mode_q) & irq_q & ~bus.irq_clr_i;
      irq_d  = 1'b0;
      case (bus.irq_mode_i)
         3'b001:  irq_d = rise_q | sticky;
         3'b010:  irq_d = fall_q | sticky;
         3'b011:  irq_d = rise_q | fall_q | sticky;
         3'b100:  irq_d = data_q;
         3'b101:  irq_d = ~data_q;
         default: irq_d = 1'b0;
      endcase
   end

   // Interrupt, previous mode and pad input enable registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_q  <= 1'b0;
         mode_q <= 3'b000;
         ie_q   <= 1'b0;
      end else begin
         irq_q  <= bus.en_i ? irq_d : 1'b0;
         mode_q <= bus.irq_mode_i;
         ie_q   <= bus.en_i;
      end
   end

`ifdef GPI_EDGE_COUNT_EN
   logic [CNT_W-1:0] edge_cnt_q;

   // Free-running accepted-edge counter; clear wins over a coincident edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 edge_cnt_q <= '0;
      else if (bus.cnt_clr_i)     edge_cnt_q <= '0;
      else if (rise_q | fall_q)   edge_cnt_q <= edge_cnt_q + CNT_W'(1);
   end

   assign bus.edge_cnt_o = edge_cnt_q;
`endif

   assign bus.ie_o   = ie_q;
   assign bus.data_o = data_q;
   assign bus.rise_o = rise_q;
   assign bus.fall_o = fall_q;
   assign bus.irq_o  = irq_q;
endmodule
